// File: rtl/event_ram_cnt_man.sv
// Per-spill event-RAM write/read counters, occupancy and capacity guard.
// Optional CNT_SNAPSHOT_EN: latch n_write/n_drop at each spill end.
module event_ram_cnt_man #(
  parameter int CNT_W    = 16,
  parameter int CAPACITY = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             live,
  input  logic             wr_done,
  input  logic             rd_done,
  output logic             live_rising,
  output logic [CNT_W-1:0] n_write,
  output logic [CNT_W-1:0] n_read,
  output logic [CNT_W-1:0] n_stored,
  output logic [CNT_W-1:0] n_drop,
  output logic             ram_full,
  output logic             ram_empty,
  output logic             overflow,
  output logic             underflow
`ifdef CNT_SNAPSHOT_EN
  ,
  output logic [CNT_W-1:0] snap_n_write,
  output logic [CNT_W-1:0] snap_n_drop,
  output logic             snap_valid
`endif
);

  localparam logic [CNT_W-1:0] CAP  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL1 = '1;

  logic             live_d;
  logic             rise;
  logic             fall;
  logic             rd_ok;
  logic             wr_ok;
  logic [CNT_W-1:0] st_rd;
  logic [CNT_W-1:0] nw_nx;
  logic [CNT_W-1:0] nr_nx;
  logic [CNT_W-1:0] ns_nx;
  logic [CNT_W-1:0] nd_nx;
  logic             ovf_nx;
  logic             unf_nx;

  assign rise = live & ~live_d;
  assign fall = ~live & live_d;

  // Read is resolved first so a write can use the slot it frees.
  always_comb begin
    rd_ok  = rd_done & (n_stored != '0);
    st_rd  = rd_ok ? n_stored - ONE : n_stored;
    wr_ok  = wr_done & (st_rd < CAP);
    nw_nx  = wr_ok ? n_write + ONE : n_write;
    nr_nx  = rd_ok ? n_read + ONE : n_read;
    ns_nx  = wr_ok ? st_rd + ONE : st_rd;
    nd_nx  = n_drop;
    if (wr_done && !wr_ok && n_drop != ALL1)
      nd_nx = n_drop + ONE;
    ovf_nx = overflow | (wr_done & ~wr_ok);
    unf_nx = underflow | (rd_done & ~rd_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_d      <= 1'b1;
      live_rising <= 1'b0;
      n_write     <= '0;
      n_read      <= '0;
      n_stored    <= '0;
      n_drop      <= '0;
      ram_full    <= 1'b0;
      ram_empty   <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      live_d      <= live;
      live_rising <= rise;
      if (rise) begin
        n_write   <= '0;
        n_read    <= '0;
        n_stored  <= '0;
        n_drop    <= '0;
        ram_full  <= 1'b0;
        ram_empty <= 1'b1;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        n_write   <= nw_nx;
        n_read    <= nr_nx;
        n_stored  <= ns_nx;
        n_drop    <= nd_nx;
        ram_full  <= (ns_nx == CAP);
        ram_empty <= (ns_nx == '0);
        overflow  <= ovf_nx;
        underflow <= unf_nx;
      end
    end
  end

`ifdef CNT_SNAPSHOT_EN
  // A fall never coincides with a rise, so nw_nx/nd_nx are the live values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_n_write <= '0;
      snap_n_drop  <= '0;
      snap_valid   <= 1'b0;
    end else begin
      snap_valid <= fall;
      if (fall) begin
        snap_n_write <= nw_nx;
        snap_n_drop  <= nd_nx;
      end
    end
  end
`else
  logic unused_fall;
  assign unused_fall = fall;
`endif

endmodule

// File: tb/tb_event_ram_cnt_man.sv
// Scoreboard bench for event_ram_cnt_man.
// Define CNT_SNAPSHOT_EN to also check the snapshot outputs.
module tb_event_ram_cnt_man;

  localparam int CAP = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        live = 1'b0;
  logic        wr_done = 1'b0;
  logic        rd_done = 1'b0;
  logic        live_rising;
  logic [15:0] n_write;
  logic [15:0] n_read;
  logic [15:0] n_stored;
  logic [15:0] n_drop;
  logic        ram_full;
  logic        ram_empty;
  logic        overflow;
  logic        underflow;
`ifdef CNT_SNAPSHOT_EN
  logic [15:0] snap_n_write;
  logic [15:0] snap_n_drop;
  logic        snap_valid;
`endif

  event_ram_cnt_man #(.CNT_W(16), .CAPACITY(CAP)) dut (
    .clk(clk),
    .rst(rst),
    .live(live),
    .wr_done(wr_done),
    .rd_done(rd_done),
    .live_rising(live_rising),
    .n_write(n_write),
    .n_read(n_read),
    .n_stored(n_stored),
    .n_drop(n_drop),
    .ram_full(ram_full),
    .ram_empty(ram_empty),
    .overflow(overflow),
    .underflow(underflow)
`ifdef CNT_SNAPSHOT_EN
    ,
    .snap_n_write(snap_n_write),
    .snap_n_drop(snap_n_drop),
    .snap_valid(snap_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lr;
    logic [15:0] nw;
    logic [15:0] nr;
    logic [15:0] ns;
    logic [15:0] nd;
    logic        full;
    logic        empty;
    logic        ov;
    logic        un;
    logic [15:0] snw;
    logic [15:0] snd;
    logic        sv;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad = 0;

  logic        m_ld;
  logic        m_lr;
  logic [15:0] m_nw, m_nr, m_ns, m_nd;
  logic        m_ov, m_un;
  logic [15:0] m_snw, m_snd;
  logic        m_sv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_cnt();
    m_nw = '0; m_nr = '0; m_ns = '0; m_nd = '0;
    m_ov = 1'b0; m_un = 1'b0;
  endtask

  task automatic push();
    exp_t e;
    e.lr = m_lr; e.nw = m_nw; e.nr = m_nr; e.ns = m_ns;
    e.nd = m_nd; e.ov = m_ov; e.un = m_un;
    e.full = (m_ns == 16'(CAP));
    e.empty = (m_ns == 16'd0);
    e.snw = m_snw; e.snd = m_snd; e.sv = m_sv;
    q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_rise"}, 32'(live_rising), 32'(e.lr));
    chk({tag, "_nw"}, 32'(n_write), 32'(e.nw));
    chk({tag, "_nr"}, 32'(n_read), 32'(e.nr));
    chk({tag, "_ns"}, 32'(n_stored), 32'(e.ns));
    chk({tag, "_nd"}, 32'(n_drop), 32'(e.nd));
    chk({tag, "_full"}, 32'(ram_full), 32'(e.full));
    chk({tag, "_empty"}, 32'(ram_empty), 32'(e.empty));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e.ov));
    chk({tag, "_unf"}, 32'(underflow), 32'(e.un));
`ifdef CNT_SNAPSHOT_EN
    chk({tag, "_snw"}, 32'(snap_n_write), 32'(e.snw));
    chk({tag, "_snd"}, 32'(snap_n_drop), 32'(e.snd));
    chk({tag, "_sv"}, 32'(snap_valid), 32'(e.sv));
`endif
  endtask

  task automatic step(input string tag, input logic w, input logic r,
                      input logic l);
    logic        rise, fall, rok, wok;
    logic [15:0] st;
    @(negedge clk);
    wr_done = w; rd_done = r; live = l;
    rise = l && !m_ld;
    fall = !l && m_ld;
    m_sv = fall;
    if (rise) begin
      clear_cnt();
      m_lr = 1'b1;
    end else begin
      m_lr = 1'b0;
      rok = r && (m_ns != 16'd0);
      st = rok ? m_ns - 16'd1 : m_ns;
      wok = w && (st < 16'(CAP));
      if (rok) m_nr = m_nr + 16'd1;
      if (wok) m_nw = m_nw + 16'd1;
      m_ns = wok ? st + 16'd1 : st;
      if (w && !wok) begin
        m_ov = 1'b1;
        if (m_nd != 16'hFFFF) m_nd = m_nd + 16'd1;
      end
      if (r && !rok) m_un = 1'b1;
    end
    if (fall) begin
      m_snw = m_nw;
      m_snd = m_nd;
    end
    m_ld = l;
    push();
    @(posedge clk);
    #1;
    pop_chk(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0; rst = 1'b1;
    clear_cnt();
    m_ld = 1'b1; m_lr = 1'b0;
    m_snw = '0; m_snd = '0; m_sv = 1'b0;
    push();
    @(posedge clk);
    #1;
    pop_chk(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset("rst");
    step("idle", 0, 0, 0);
    step("idle", 0, 0, 0);
    step("idle", 0, 0, 0);
    step("rise", 0, 0, 1);
    step("post", 0, 0, 1);

    for (int i = 0; i < 10; i++) step("wr10", 1, 0, 1);
    for (int i = 0; i < 4; i++) step("rd4", 0, 1, 1);

    step("fall", 0, 0, 0);
    step("rise2", 0, 0, 1);
    for (int i = 0; i < 66; i++) step("wr66", 1, 0, 1);
    step("fullpair", 1, 1, 1);
    step("fullwr", 1, 0, 1);

    step("fall", 0, 0, 0);
    step("rise3", 0, 0, 1);
    step("emptypair", 1, 1, 1);
    step("drain", 0, 1, 1);
    step("underrd", 0, 1, 1);

    step("fall", 0, 0, 0);
    step("rise4", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("pre3", 1, 0, 1);
    for (int i = 0; i < 65530; i++) step("bulk", 1, 1, 1);
    for (int i = 0; i < 10; i++) step("wrap", 1, 1, 1);

    do_reset("rst_live");
    for (int i = 0; i < 3; i++) step("nopulse", 0, 0, 1);
    for (int i = 0; i < 5; i++) step("wr5", 1, 0, 1);
    step("fall_snap", 0, 0, 0);
    step("hold_snap", 0, 1, 0);
    step("rise5", 0, 0, 1);
    step("post5", 0, 0, 1);

    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
